// File: rtl/xspi_cmd_seq_if.sv
// xSPI command sequencer bus: PHY transaction signals plus flash backend port.
// master = sequencer side, slave = PHY/backend side.
interface xspi_cmd_seq_if #(
  parameter int WORD_SIZE        = 32,
  parameter int CYCLE_COUNT_BITS = 6,
  parameter int ADDR_BITS        = 24
);
  logic [CYCLE_COUNT_BITS-1:0] txnbc_o;
  logic [1:0]                  txnmode_o;
  logic                        txndir_o;
  logic [WORD_SIZE-1:0]        txndata_o;
  logic [WORD_SIZE-1:0]        txndata_i;
  logic                        txndone_i;
  logic [ADDR_BITS-1:0]        addr_o;
  logic                        rd_req_o;
  logic [WORD_SIZE-1:0]        rd_data_i;
  logic                        rd_valid_i;
  logic [WORD_SIZE-1:0]        wr_data_o;
  logic                        wr_valid_o;
  logic [7:0]                  status_i;
  logic                        wel_set_o;
  logic                        wel_clr_o;
  logic                        cmd_err_o;
  logic                        underrun_o;

  modport master (
    output txnbc_o, txnmode_o, txndir_o, txndata_o,
    input  txndata_i, txndone_i,
    output addr_o, rd_req_o,
    input  rd_data_i, rd_valid_i,
    output wr_data_o, wr_valid_o,
    input  status_i,
    output wel_set_o, wel_clr_o, cmd_err_o, underrun_o
  );

  modport slave (
    input  txnbc_o, txnmode_o, txndir_o, txndata_o,
    output txndata_i, txndone_i,
    input  addr_o, rd_req_o,
    output rd_data_i, rd_valid_i,
    input  wr_data_o, wr_valid_o,
    output status_i,
    input  wel_set_o, wel_clr_o, cmd_err_o, underrun_o
  );
endinterface

// File: rtl/xspi_cmd_seq.sv
// xSPI command sequencer: opcode decode, CMD/ADDR/DUMMY/DATA phase control.
// Ports: sck_i (falling-edge clock), sce_i (async low reset), bus (master).
module xspi_cmd_seq #(
  parameter int WORD_SIZE        = 32,
  parameter int CYCLE_COUNT_BITS = 6,
  parameter int ADDR_BITS        = 24,
  parameter int DUMMY_CYCLES     = 8,
  parameter logic [WORD_SIZE-1:0] JEDEC_ID = 'h00EF4018
) (
  input  logic           sck_i,
  input  logic           sce_i,
  xspi_cmd_seq_if.master bus
);

  localparam int CB = CYCLE_COUNT_BITS;
  localparam int W  = WORD_SIZE;
  localparam int A  = ADDR_BITS;

  localparam logic [CB-1:0] BC_CMD  = CB'(8);
  localparam logic [CB-1:0] BC_ADDR = CB'(A);
  localparam logic [CB-1:0] BC_WORD = CB'(W);
  localparam logic [CB-1:0] BC_DUM  = CB'(DUMMY_CYCLES);
  localparam logic [A-1:0]  AINC    = A'(W / 8);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_SINK
  } state_t;

  typedef enum logic [1:0] {
    R_MEM, R_STAT, R_ID
  } rsrc_t;

  state_t        state;
  rsrc_t         rsrc;
  logic [1:0]    am_q;
  logic [1:0]    dm_q;
  logic [1:0]    xm_q;
  logic          is_rd;
  logic          wel_q;
  logic          inc_pend;

  logic [CB-1:0] bc_q;
  logic [1:0]    mode_q;
  logic [W-1:0]  data_q;
  logic [A-1:0]  addr_q;
  logic          rd_req_q;
  logic [W-1:0]  wdat_q;
  logic          wval_q;
  logic          set_q;
  logic          clr_q;
  logic          err_q;
  logic          urun_q;

  logic [7:0]    op;
  logic          op_ok;
  logic          op_rd;
  logic          op_set;
  logic          op_clr;
  logic [1:0]    op_am;
  logic [1:0]    op_dm;
  logic [1:0]    op_xm;
  rsrc_t         op_src;
  state_t        op_nxt;

  logic [W-1:0]  stat_w;
  logic [W-1:0]  mem_w;
  logic [W-1:0]  load_w;
  logic          cur_dir;
  logic          nxt_dir;

  assign op = bus.txndata_i[7:0];

  always_comb begin
    op_ok  = 1'b1;
    op_rd  = 1'b0;
    op_set = 1'b0;
    op_clr = 1'b0;
    op_am  = 2'b00;
    op_dm  = 2'b00;
    op_xm  = 2'b00;
    op_src = R_MEM;
    op_nxt = S_SINK;
    unique case (1'b1)
      op == 8'h0B: begin
        op_rd  = 1'b1;
        op_nxt = S_ADDR;
      end
      op == 8'h6B: begin
        op_rd  = 1'b1;
        op_xm  = 2'b10;
        op_nxt = S_ADDR;
      end
      op == 8'hEB: begin
        op_rd  = 1'b1;
        op_am  = 2'b10;
        op_dm  = 2'b10;
        op_xm  = 2'b10;
        op_nxt = S_ADDR;
      end
      op == 8'h02: begin
        op_nxt = S_ADDR;
      end
      op == 8'h32: begin
        op_xm  = 2'b10;
        op_nxt = S_ADDR;
      end
      op == 8'h05: begin
        op_src = R_STAT;
        op_nxt = S_RDATA;
      end
      op == 8'h9F: begin
        op_src = R_ID;
        op_nxt = S_RDATA;
      end
      op == 8'h06: op_set = 1'b1;
      op == 8'h04: op_clr = 1'b1;
      default:     op_ok  = 1'b0;
    endcase
  end

  assign stat_w = {{(W-8){1'b0}}, bus.status_i};
  assign mem_w  = bus.rd_valid_i ? bus.rd_data_i : '0;

  always_comb begin
    load_w = mem_w;
    unique case (rsrc)
      R_STAT:  load_w = stat_w;
      R_ID:    load_w = JEDEC_ID;
      default: load_w = mem_w;
    endcase
  end

  // Look ahead one phase on the done edge so the PHY can register
  // its output enable for the upcoming phase on that same edge.
  assign cur_dir = (state == S_RDATA);

  always_comb begin
    nxt_dir = 1'b0;
    unique case (state)
      S_CMD:   nxt_dir = (op_nxt == S_RDATA);
      S_DUMMY: nxt_dir = 1'b1;
      S_RDATA: nxt_dir = 1'b1;
      default: nxt_dir = 1'b0;
    endcase
  end

  assign bus.txndir_o   = bus.txndone_i ? nxt_dir : cur_dir;
  assign bus.txnbc_o    = bc_q;
  assign bus.txnmode_o  = mode_q;
  assign bus.txndata_o  = data_q;
  assign bus.addr_o     = addr_q;
  assign bus.rd_req_o   = rd_req_q;
  assign bus.wr_data_o  = wdat_q;
  assign bus.wr_valid_o = wval_q;
  assign bus.wel_set_o  = set_q;
  assign bus.wel_clr_o  = clr_q;
  assign bus.cmd_err_o  = err_q;
  assign bus.underrun_o = urun_q;

  always_ff @(negedge sck_i or negedge sce_i) begin
    if (!sce_i) begin
      state    <= S_CMD;
      rsrc     <= R_MEM;
      am_q     <= 2'b00;
      dm_q     <= 2'b00;
      xm_q     <= 2'b00;
      is_rd    <= 1'b0;
      wel_q    <= 1'b0;
      inc_pend <= 1'b0;
      bc_q     <= BC_CMD;
      mode_q   <= 2'b00;
      data_q   <= '0;
      addr_q   <= '0;
      rd_req_q <= 1'b0;
      wdat_q   <= '0;
      wval_q   <= 1'b0;
      set_q    <= 1'b0;
      clr_q    <= 1'b0;
      err_q    <= 1'b0;
      urun_q   <= 1'b0;
    end else begin
      rd_req_q <= 1'b0;
      wval_q   <= 1'b0;
      set_q    <= 1'b0;
      clr_q    <= 1'b0;
      // Write address advances one edge after the strobe so the
      // strobe carries the address of the word just programmed.
      if (inc_pend) begin
        addr_q   <= addr_q + AINC;
        inc_pend <= 1'b0;
      end
      if (bus.txndone_i) begin
        unique case (state)
          S_CMD: begin
            am_q  <= op_am;
            dm_q  <= op_dm;
            xm_q  <= op_xm;
            is_rd <= op_rd;
            rsrc  <= op_src;
            wel_q <= bus.status_i[1];
            set_q <= op_set;
            clr_q <= op_clr;
            state <= op_nxt;
            if (!op_ok) begin
              err_q <= 1'b1;
            end
            if (op_nxt == S_ADDR) begin
              bc_q   <= BC_ADDR;
              mode_q <= op_am;
            end else if (op_nxt == S_RDATA) begin
              bc_q   <= (op_src == R_STAT) ? BC_CMD : BC_WORD;
              mode_q <= 2'b00;
              data_q <= (op_src == R_STAT) ? stat_w : JEDEC_ID;
            end else begin
              bc_q   <= BC_WORD;
              mode_q <= 2'b00;
            end
          end
          S_ADDR: begin
            addr_q <= bus.txndata_i[A-1:0];
            if (is_rd) begin
              rd_req_q <= 1'b1;
              state    <= S_DUMMY;
              bc_q     <= BC_DUM << dm_q;
              mode_q   <= dm_q;
            end else begin
              state  <= S_WDATA;
              bc_q   <= BC_WORD;
              mode_q <= xm_q;
            end
          end
          S_DUMMY, S_RDATA: begin
            data_q <= load_w;
            if (state == S_DUMMY) begin
              state  <= S_RDATA;
              bc_q   <= BC_WORD;
              mode_q <= xm_q;
            end
            if (rsrc == R_MEM) begin
              addr_q   <= addr_q + AINC;
              rd_req_q <= 1'b1;
              if (!bus.rd_valid_i) begin
                urun_q <= 1'b1;
              end
            end
          end
          S_WDATA: begin
            wdat_q   <= bus.txndata_i;
            wval_q   <= wel_q;
            inc_pend <= 1'b1;
          end
          default: begin
            state <= S_SINK;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/xspi_cmd_seq.md
Name: xspi_cmd_seq

Overview:
- Command sequencer for xspi_phy_slave. Decodes the 8-bit opcode from the host and drives the PHY transaction interface through the phases CMD, ADDR, DUMMY and DATA.
- Bridges data words to and from a flash backend (address, read request/response, write strobe).
- Clocked by the SPI clock, reset by chip-select deassertion. One instance sits between xspi_phy_io/xspi_phy_slave and the backend.

Parameters:
WORD_SIZE, 32, data word bits; matches PHY WORD_SIZE.
CYCLE_COUNT_BITS, 6, PHY bit-count width; requires ADDR_BITS, WORD_SIZE, 4*DUMMY_CYCLES <= 2**CYCLE_COUNT_BITS-1.
ADDR_BITS, 24, address phase bits; requires ADDR_BITS <= WORD_SIZE.
DUMMY_CYCLES, 8, dummy bus cycles for fast reads.
JEDEC_ID, 32'h00EF4018, word returned by 0x9F.

Ports:
sck_i  in  1  SPI clock; all state updates on falling edge.
sce_i  in  1  chip enable; async active-low reset (low = reset).
txnbc_o  out  CYCLE_COUNT_BITS  PHY bit count.
txnmode_o  out  2  PHY lane mode (00/01/10/11 = 1/2/4/8 lanes).
txndir_o  out  1  PHY direction, 1 = slave drives bus.
txndata_o  out  WORD_SIZE  word to PHY.
txndata_i  in  WORD_SIZE  word from PHY.
txndone_i  in  1  PHY transaction done.
addr_o  out  ADDR_BITS  backend address.
rd_req_o  out  1  one-cycle read request for addr_o.
rd_data_i  in  WORD_SIZE  backend read word.
rd_valid_i  in  1  rd_data_i valid.
wr_data_o  out  WORD_SIZE  program word.
wr_valid_o  out  1  one-cycle strobe; wr_data_o/addr_o valid.
status_i  in  8  backend status; bit1 = WEL.
wel_set_o, wel_clr_o  out  1  one-cycle pulses.
cmd_err_o  out  1  unsupported opcode; held until reset.
underrun_o  out  1  read word missing; held until reset.

Behaviour:
Reset (sce_i low, async) values:
- State CMD; txnbc_o=8, txnmode_o=00, txndata_o=0.
- addr_o=0, wr_data_o=0; all pulses and flags 0.

Advance:
- State advances only on a falling sck_i edge with txndone_i=1 (exactly one per PHY transaction).
- Pulses last one sck cycle (falling edge to falling edge).

txndir_o:
- The only combinational output: txndone_i ? next-phase direction : current-phase direction.
- This lets the PHY register sio_oe correctly on the same edge.

States:
- CMD: 8 bits, mode 00, input.
- ADDR: ADDR_BITS bits, input.
- DUMMY: bit count = DUMMY_CYCLES << mode, input.
- RDATA: output, repeats until reset.
- WDATA: input, repeats until reset.
- SINK: WORD_SIZE bits, mode 00, input; loops, discards everything.

Opcode table (opcode: addr mode / dummy mode / data mode, direction):
- 0x0B: 00 / 00 / 00, read.
- 0x6B: 00 / 00 / 10, read.
- 0xEB: 10 / 10 / 10, read.
- 0x02: 00 / - / 00, write.
- 0x32: 00 / - / 10, write.
- 0x05: no address; RDATA 8 bits, mode 00; txndata_o = status_i sampled at each word load.
- 0x9F: no address; RDATA WORD_SIZE bits, mode 00; txndata_o = JEDEC_ID every word.
- 0x06: wel_set_o pulse, then SINK.
- 0x04: wel_clr_o pulse, then SINK.
- Any other opcode: cmd_err_o=1, then SINK.

Address and read flow:
- At ADDR done: addr_o <= txndata_i[ADDR_BITS-1:0]. For reads, rd_req_o pulses.
- At DUMMY done and at each RDATA done:
  - txndata_o <= rd_data_i if rd_valid_i, else 0 and underrun_o=1.
  - addr_o += WORD_SIZE/8, then rd_req_o pulses for the new address.
  - Backend latency budget is therefore one full phase.

Write flow:
- WEL = status_i[1] is sampled at CMD done for 0x02/0x32.
- At each WDATA done: wr_data_o <= txndata_i. wr_valid_o pulses only if the sampled WEL was 1. addr_o then increments by WORD_SIZE/8 on the following edge.

Arithmetic and boundaries:
- Address increment wraps modulo 2**ADDR_BITS.
- A partial final word is never strobed; sce_i deassertion aborts immediately and any in-flight word is dropped.
- txnbc_o/txnmode_o change only on txndone edges.

Test Plan:
- 0x0B, addr 0x000100, rd_data_i=0xA5A5A5A5 valid before dummy done -> rd_req_o at ADDR done; 32 single-lane bits out = 0xA5A5A5A5; second rd_req_o with addr_o=0x000104.
- 0xEB, addr quad 0x123456, DUMMY_CYCLES=8 -> txnbc_o sequence 8, 24, 32, 32; txnmode_o 00, 10, 10, 10; txndir_o reaches the PHY high on the first data cycle.
- 0x02 with status_i=0x02, two words 0xDEADBEEF, 0x01234567 at addr 0xFFFFFC -> wr_valid_o twice: addr 0xFFFFFC then 0x000000 (wrap). Repeat with status_i=0x00 -> no wr_valid_o.
- 0x9F -> 0x00EF4018 shifted out MSB first; 0x05 with status_i=0x03 -> 0x03 out, repeated.
- Opcode 0xFF -> cmd_err_o=1, no strobes, txndir_o stays 0; sce_i low clears cmd_err_o and returns to CMD.
- sce_i low after 12 address bits, then new 0x06 -> all state reset; wel_set_o pulses once; no rd_req_o.
